// File: rtl/rggen_rtl_pkg.sv
// Shared rggen types: register-bus access kinds, response status codes and
// the Wishbone responder bridge state encoding.
package rggen_rtl_pkg;

    typedef enum logic [1:0] {
        RGGEN_READ  = 2'b10,
        RGGEN_WRITE = 2'b11
    } rggen_access;

    typedef enum logic [1:0] {
        RGGEN_OKAY         = 2'b00,
        RGGEN_EXOKAY       = 2'b01,
        RGGEN_SLAVE_ERROR  = 2'b10,
        RGGEN_DECODE_ERROR = 2'b11
    } rggen_status;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        BUSY    = 2'b01,
        RESPOND = 2'b10
    } rggen_wishbone_slave_state_e;

    // OKAY and EXOKAY both complete the Wishbone cycle with ack; anything else is err.
    function automatic logic rggen_status_is_ok(input rggen_status status);
        return (status == RGGEN_OKAY) || (status == RGGEN_EXOKAY);
    endfunction

endpackage

// File: rtl/rggen_bus_if.sv
// rggen register-bus bundle between a bus bridge (master) and a register block.
interface rggen_bus_if #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int BUS_WIDTH     = 32
);
    import rggen_rtl_pkg::*;

    logic                     valid;
    rggen_access              access;
    logic [ADDRESS_WIDTH-1:0] address;
    logic [BUS_WIDTH-1:0]     write_data;
    logic [BUS_WIDTH/8-1:0]   strobe;
    logic                     ready;
    rggen_status              status;
    logic [BUS_WIDTH-1:0]     read_data;

    modport master (
        output valid, access, address, write_data, strobe,
        input  ready, status, read_data
    );

    modport slave (
        input  valid, access, address, write_data, strobe,
        output ready, status, read_data
    );
endinterface

// File: rtl/rggen_wishbone_if.sv
// Wishbone B4 bus bundle; the initiator drives the request side, the
// responder drives stall and the termination signals.
interface rggen_wishbone_if #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 32
);
    logic                      cyc;
    logic                      stb;
    logic                      stall;
    logic [ADDRESS_WIDTH-1:0]  adr;
    logic                      we;
    logic [DATA_WIDTH-1:0]     dat_w;
    logic [DATA_WIDTH/8-1:0]   sel;
    logic                      ack;
    logic                      err;
    logic                      rty;
    logic [DATA_WIDTH-1:0]     dat_r;

    modport master (
        output cyc, stb, adr, we, dat_w, sel,
        input  stall, ack, err, rty, dat_r
    );

    modport slave (
        input  cyc, stb, adr, we, dat_w, sel,
        output stall, ack, err, rty, dat_r
    );
endinterface

// File: rtl/rggen_wishbone_slave_bridge.sv
// Wishbone B4 responder front-end for an rggen register block.
// One Wishbone transfer is registered, replayed on rggen_bus_if, and the
// register block's status is returned as a one-cycle ack or err.
//
// Handshake: a register request is transferred on the cycle where
// bus_if.valid && bus_if.ready; valid stays high with stable request fields
// until then and is never withdrawn once raised (except by the optional
// watchdog). A Wishbone request is taken when cyc && stb in IDLE; in pipelined
// mode stall is high in every non-IDLE state so the initiator holds its next stb.
//
// Optional watchdog: define RGGEN_WISHBONE_TIMEOUT_EN to abort a BUSY phase
// that sees no ready for TIMEOUT_CYCLES cycles and answer it with err.
module rggen_wishbone_slave_bridge
    import rggen_rtl_pkg::*;
#(
    parameter int ADDRESS_WIDTH  = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int USE_STALL      = 1,
    parameter int TIMEOUT_CYCLES = 256
)(
    input  logic                        i_clk,
    input  logic                        i_rst,
    rggen_wishbone_if.slave             wishbone_if,
    rggen_bus_if.master                 bus_if,
    output rggen_wishbone_slave_state_e debug_state
);

    localparam int STROBE_WIDTH = DATA_WIDTH / 8;

    rggen_wishbone_slave_state_e state;
    rggen_wishbone_slave_state_e state_next;

    logic                     drop_q;
    logic                     drop_next;
    rggen_access              access_q;
    logic [ADDRESS_WIDTH-1:0] address_q;
    logic [DATA_WIDTH-1:0]    write_data_q;
    logic [STROBE_WIDTH-1:0]  strobe_q;
    logic                     ack_q;
    logic                     err_q;
    logic [DATA_WIDTH-1:0]    dat_r_q;

    logic                     accept;
    logic                     handshake;
    logic                     timed_out;
    logic                     respond_ok;
    logic                     respond_err;
    logic [DATA_WIDTH-1:0]    respond_data;

    assign accept    = (state == IDLE) && wishbone_if.cyc && wishbone_if.stb;
    assign handshake = (state == BUSY) && bus_if.ready;

`ifdef RGGEN_WISHBONE_TIMEOUT_EN
    localparam int                     COUNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [COUNT_WIDTH-1:0] COUNT_LAST  = COUNT_WIDTH'(TIMEOUT_CYCLES - 1);

    logic [COUNT_WIDTH-1:0] timeout_count;

    // Watchdog: restart on every accepted request, count BUSY cycles without ready.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            timeout_count <= '0;
        end else if (accept) begin
            timeout_count <= '0;
        end else if ((state == BUSY) && !bus_if.ready) begin
            timeout_count <= timeout_count + COUNT_WIDTH'(1);
        end
    end

    // A ready arriving on the expiry cycle takes priority over the timeout.
    assign timed_out = (state == BUSY) && !bus_if.ready && (timeout_count == COUNT_LAST);
`else
    assign timed_out = 1'b0;
`endif

    // State and drop-flag registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state  <= IDLE;
            drop_q <= 1'b0;
        end else begin
            state  <= state_next;
            drop_q <= drop_next;
        end
    end

    // Next-state logic; losing cyc while BUSY marks the response as dropped.
    always_comb begin
        state_next = state;
        drop_next  = drop_q;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_next = BUSY;
                    drop_next  = 1'b0;
                end
            end
            BUSY: begin
                if (!wishbone_if.cyc) begin
                    drop_next = 1'b1;
                end
                if (handshake || timed_out) begin
                    state_next = RESPOND;
                end
            end
            RESPOND: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Response decode on the BUSY->RESPOND edge; zero at all other times.
    always_comb begin
        respond_ok   = handshake && rggen_status_is_ok(bus_if.status) && !drop_next;
        respond_err  = ((handshake && !rggen_status_is_ok(bus_if.status)) || timed_out)
                       && !drop_next;
        respond_data = '0;
        if (respond_ok && (access_q == RGGEN_READ)) begin
            respond_data = bus_if.read_data;
        end
    end

    // Request capture; fields hold until the next accepted transfer.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            access_q     <= RGGEN_READ;
            address_q    <= '0;
            write_data_q <= '0;
            strobe_q     <= '0;
        end else if (accept) begin
            access_q     <= wishbone_if.we ? RGGEN_WRITE : RGGEN_READ;
            address_q    <= wishbone_if.adr;
            write_data_q <= wishbone_if.dat_w;
            strobe_q     <= wishbone_if.sel;
        end
    end

    // Registered termination: ack/err/dat_r live exactly for the RESPOND cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dat_r_q <= '0;
        end else begin
            ack_q   <= respond_ok;
            err_q   <= respond_err;
            dat_r_q <= respond_data;
        end
    end

    // A cyc drop during RESPOND still has to suppress the termination pulse.
    assign wishbone_if.ack   = ack_q && wishbone_if.cyc;
    assign wishbone_if.err   = err_q && wishbone_if.cyc;
    assign wishbone_if.rty   = 1'b0;
    assign wishbone_if.dat_r = dat_r_q;
    assign wishbone_if.stall = (USE_STALL != 0) && (state != IDLE);

    assign bus_if.valid      = (state == BUSY);
    assign bus_if.access     = access_q;
    assign bus_if.address    = address_q;
    assign bus_if.write_data = write_data_q;
    assign bus_if.strobe     = strobe_q;

    assign debug_state = state;

endmodule

// File: tb/tb_rggen_wishbone_slave_bridge.sv
// Directed bench for rggen_wishbone_slave_bridge: a pipelined instance
// (TIMEOUT_CYCLES=8) and a classic instance side by side.
module tb_rggen_wishbone_slave_bridge;
    import rggen_rtl_pkg::*;

    localparam int AW = 16;
    localparam int DW = 32;

    // clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rggen_wishbone_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) wb0 ();
    rggen_bus_if      #(.ADDRESS_WIDTH(AW), .BUS_WIDTH(DW))  bus0 ();
    rggen_wishbone_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) wb1 ();
    rggen_bus_if      #(.ADDRESS_WIDTH(AW), .BUS_WIDTH(DW))  bus1 ();

    rggen_wishbone_slave_state_e state0;
    rggen_wishbone_slave_state_e state1;

    int checks = 0;
    int errors = 0;

    rggen_wishbone_slave_bridge #(
        .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .USE_STALL(1), .TIMEOUT_CYCLES(8)
    ) dut0 (
        .i_clk(clk), .i_rst(rst), .wishbone_if(wb0), .bus_if(bus0), .debug_state(state0)
    );

    rggen_wishbone_slave_bridge #(
        .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .USE_STALL(0), .TIMEOUT_CYCLES(8)
    ) dut1 (
        .i_clk(clk), .i_rst(rst), .wishbone_if(wb1), .bus_if(bus1), .debug_state(state1)
    );

    // driver tasks: inputs change 1 time unit after the rising edge,
    // outputs are sampled 3 time units after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        #2;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        wb0.cyc = 1'b0; wb0.stb = 1'b0; wb0.we = 1'b0; wb0.adr = '0; wb0.dat_w = '0; wb0.sel = '0;
        wb1.cyc = 1'b0; wb1.stb = 1'b0; wb1.we = 1'b0; wb1.adr = '0; wb1.dat_w = '0; wb1.sel = '0;
        bus0.ready = 1'b0; bus0.status = RGGEN_OKAY; bus0.read_data = '0;
        bus1.ready = 1'b0; bus1.status = RGGEN_OKAY; bus1.read_data = '0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();

        // reset values
        step(); look();
        chk("rst_ack",        wb0.ack, 0);
        chk("rst_err",        wb0.err, 0);
        chk("rst_rty",        wb0.rty, 0);
        chk("rst_stall",      wb0.stall, 0);
        chk("rst_dat_r",      wb0.dat_r, 0);
        chk("rst_valid",      bus0.valid, 0);
        chk("rst_address",    bus0.address, 0);
        chk("rst_write_data", bus0.write_data, 0);
        chk("rst_strobe",     bus0.strobe, 0);
        chk("rst_access",     bus0.access, RGGEN_READ);
        chk("rst_state",      state0, IDLE);
        step(); rst = 1'b0;

        // write 0x0010, ready in first BUSY cycle
        step();
        wb0.cyc = 1'b1; wb0.stb = 1'b1; wb0.we = 1'b1; wb0.adr = 16'h0010;
        wb0.dat_w = 32'hDEADBEEF; wb0.sel = 4'hF;
        bus0.ready = 1'b1; bus0.status = RGGEN_OKAY;
        look();
        chk("wr_accept_stall", wb0.stall, 0);
        step(); wb0.stb = 1'b0; look();
        chk("wr_valid",      bus0.valid, 1);
        chk("wr_access",     bus0.access, RGGEN_WRITE);
        chk("wr_address",    bus0.address, 16'h0010);
        chk("wr_write_data", bus0.write_data, 32'hDEADBEEF);
        chk("wr_strobe",     bus0.strobe, 4'hF);
        chk("wr_busy_stall", wb0.stall, 1);
        chk("wr_busy_ack",   wb0.ack, 0);
        step(); look();
        chk("wr_ack",   wb0.ack, 1);
        chk("wr_err",   wb0.err, 0);
        chk("wr_valid_low", bus0.valid, 0);
        step(); wb0.cyc = 1'b0; bus0.ready = 1'b0; look();
        chk("wr_ack_done", wb0.ack, 0);
        chk("wr_idle",     state0, IDLE);

        // read 0x0020, ready on the fourth BUSY cycle
        step();
        wb0.cyc = 1'b1; wb0.stb = 1'b1; wb0.we = 1'b0; wb0.adr = 16'h0020;
        look();
        step(); wb0.stb = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                bus0.ready = 1'b1; bus0.read_data = 32'h12345678; bus0.status = RGGEN_OKAY;
            end
            look();
            chk("rd_valid_hold",   bus0.valid, 1);
            chk("rd_address_hold", bus0.address, 16'h0020);
            chk("rd_stall_hold",   wb0.stall, 1);
            chk("rd_no_early_ack", wb0.ack, 0);
            step();
        end
        bus0.ready = 1'b0; bus0.read_data = '0; look();
        chk("rd_ack",   wb0.ack, 1);
        chk("rd_err",   wb0.err, 0);
        chk("rd_dat_r", wb0.dat_r, 32'h12345678);
        chk("rd_resp_stall", wb0.stall, 1);
        step(); wb0.cyc = 1'b0; look();
        chk("rd_ack_done",   wb0.ack, 0);
        chk("rd_dat_r_done", wb0.dat_r, 0);

        // read answered with SLAVE_ERROR
        step();
        wb0.cyc = 1'b1; wb0.stb = 1'b1; wb0.we = 1'b0; wb0.adr = 16'h0024;
        bus0.ready = 1'b1; bus0.status = RGGEN_SLAVE_ERROR; bus0.read_data = 32'hCAFEF00D;
        look();
        step(); wb0.stb = 1'b0; look();
        chk("er_valid", bus0.valid, 1);
        step(); look();
        chk("er_err",   wb0.err, 1);
        chk("er_ack",   wb0.ack, 0);
        chk("er_dat_r", wb0.dat_r, 0);
        step(); wb0.cyc = 1'b0; bus0.ready = 1'b0; bus0.status = RGGEN_OKAY; look();
        chk("er_err_done", wb0.err, 0);

        // cyc dropped in the second BUSY cycle
        step();
        wb0.cyc = 1'b1; wb0.stb = 1'b1; wb0.we = 1'b0; wb0.adr = 16'h0028;
        look();
        step(); wb0.stb = 1'b0; look();
        chk("ab_busy1_valid", bus0.valid, 1);
        step(); wb0.cyc = 1'b0; look();
        chk("ab_busy2_valid", bus0.valid, 1);
        step(); bus0.ready = 1'b1; bus0.read_data = 32'h00000055; look();
        chk("ab_busy3_valid", bus0.valid, 1);
        step(); bus0.ready = 1'b0; look();
        chk("ab_resp_state", state0, RESPOND);
        chk("ab_resp_ack",   wb0.ack, 0);
        chk("ab_resp_err",   wb0.err, 0);
        chk("ab_resp_dat_r", wb0.dat_r, 0);
        step(); look();
        chk("ab_idle", state0, IDLE);

        // next transfer after the abort: write 0x0030, EXOKAY
        step();
        wb0.cyc = 1'b1; wb0.stb = 1'b1; wb0.we = 1'b1; wb0.adr = 16'h0030;
        wb0.dat_w = 32'h0A0B0C0D; wb0.sel = 4'h3;
        bus0.ready = 1'b1; bus0.status = RGGEN_EXOKAY;
        look();
        step(); wb0.stb = 1'b0; look();
        chk("nx_address",    bus0.address, 16'h0030);
        chk("nx_strobe",     bus0.strobe, 4'h3);
        chk("nx_write_data", bus0.write_data, 32'h0A0B0C0D);
        step(); look();
        chk("nx_ack",   wb0.ack, 1);
        chk("nx_err",   wb0.err, 0);
        chk("nx_dat_r", wb0.dat_r, 0);
        step(); wb0.cyc = 1'b0; bus0.ready = 1'b0; bus0.status = RGGEN_OKAY; look();

        // pipelined back-to-back reads 0x4 then 0x8 with stb held
        step();
        wb0.cyc = 1'b1; wb0.stb = 1'b1; wb0.we = 1'b0; wb0.adr = 16'h0004;
        look();
        chk("pl_first_stall", wb0.stall, 0);
        step(); wb0.adr = 16'h0008; bus0.ready = 1'b1; bus0.read_data = 32'h00001004; look();
        chk("pl_addr_a",  bus0.address, 16'h0004);
        chk("pl_stall_a", wb0.stall, 1);
        step(); look();
        chk("pl_ack_a",   wb0.ack, 1);
        chk("pl_dat_a",   wb0.dat_r, 32'h00001004);
        chk("pl_stall_r", wb0.stall, 1);
        chk("pl_state_r", state0, RESPOND);
        step(); look();
        chk("pl_stall_i", wb0.stall, 0);
        chk("pl_ack_i",   wb0.ack, 0);
        chk("pl_state_i", state0, IDLE);
        step(); wb0.stb = 1'b0; bus0.read_data = 32'h00001008; look();
        chk("pl_valid_b", bus0.valid, 1);
        chk("pl_addr_b",  bus0.address, 16'h0008);
        step(); look();
        chk("pl_ack_b", wb0.ack, 1);
        chk("pl_dat_b", wb0.dat_r, 32'h00001008);
        step(); wb0.cyc = 1'b0; bus0.ready = 1'b0; look();
        chk("pl_ack_end",   wb0.ack, 0);
        chk("pl_state_end", state0, IDLE);

        // classic instance: initiator holds stb/adr until ack
        step();
        wb1.cyc = 1'b1; wb1.stb = 1'b1; wb1.we = 1'b0; wb1.adr = 16'h0004;
        bus1.ready = 1'b1; bus1.read_data = 32'h00002004;
        look();
        chk("cl_idle_stall", wb1.stall, 0);
        step(); look();
        chk("cl_valid_a", bus1.valid, 1);
        chk("cl_addr_a",  bus1.address, 16'h0004);
        chk("cl_busy_stall", wb1.stall, 0);
        step(); look();
        chk("cl_ack_a",   wb1.ack, 1);
        chk("cl_dat_a",   wb1.dat_r, 32'h00002004);
        chk("cl_resp_stall", wb1.stall, 0);
        chk("cl_state_r", state1, RESPOND);
        step(); wb1.adr = 16'h0008; bus1.read_data = 32'h00002008; look();
        chk("cl_state_i", state1, IDLE);
        chk("cl_ack_i",   wb1.ack, 0);
        step(); look();
        chk("cl_valid_b", bus1.valid, 1);
        chk("cl_addr_b",  bus1.address, 16'h0008);
        step(); look();
        chk("cl_ack_b", wb1.ack, 1);
        chk("cl_dat_b", wb1.dat_r, 32'h00002008);
        step(); wb1.cyc = 1'b0; wb1.stb = 1'b0; bus1.ready = 1'b0; look();
        chk("cl_state_end", state1, IDLE);
        chk("cl_ack_end",   wb1.ack, 0);

`ifdef RGGEN_WISHBONE_TIMEOUT_EN
        // watchdog: ready never arrives
        step();
        wb0.cyc = 1'b1; wb0.stb = 1'b1; wb0.we = 1'b0; wb0.adr = 16'h0040;
        bus0.ready = 1'b0; bus0.read_data = 32'hFFFFFFFF;
        look();
        step(); wb0.stb = 1'b0;
        for (int i = 0; i < 8; i++) begin
            look();
            chk("to_valid_hold", bus0.valid, 1);
            step();
        end
        look();
        chk("to_valid_low", bus0.valid, 0);
        chk("to_err",       wb0.err, 1);
        chk("to_ack",       wb0.ack, 0);
        chk("to_dat_r",     wb0.dat_r, 0);
        chk("to_state",     state0, RESPOND);
        step(); wb0.cyc = 1'b0; look();
        chk("to_err_done",  wb0.err, 0);
        chk("to_idle",      state0, IDLE);
`endif

        // asynchronous reset in the middle of BUSY
        step();
        wb0.cyc = 1'b1; wb0.stb = 1'b1; wb0.we = 1'b1; wb0.adr = 16'h0050;
        wb0.dat_w = 32'h11223344; wb0.sel = 4'hF; bus0.ready = 1'b0;
        look();
        step(); wb0.stb = 1'b0; look();
        chk("ar_busy_valid", bus0.valid, 1);
        #1; rst = 1'b1; #1;
        chk("ar_valid",      bus0.valid, 0);
        chk("ar_stall",      wb0.stall, 0);
        chk("ar_state",      state0, IDLE);
        chk("ar_address",    bus0.address, 0);
        chk("ar_write_data", bus0.write_data, 0);
        chk("ar_strobe",     bus0.strobe, 0);
        chk("ar_access",     bus0.access, RGGEN_READ);
        chk("ar_ack",        wb0.ack, 0);
        step(); rst = 1'b0; bus0.ready = 1'b1; look();
        chk("ar_post_state", state0, IDLE);
        chk("ar_post_valid", bus0.valid, 0);
        step(); look();
        chk("ar_no_ack", wb0.ack, 0);
        chk("ar_no_err", wb0.err, 0);
        step(); wb0.cyc = 1'b0; bus0.ready = 1'b0;

        // final report
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
